twos_to_signmag: RTL



---
 rtl/twos_to_signmag_if.sv | 25 ++
 rtl/twos_to_signmag.sv | 115 +++++++++++
 2 files changed

// File: rtl/twos_to_signmag_if.sv
// Handshake bundle for the two's-complement to sign-magnitude decoder:
// word input, result output and the busy status flag.
interface twos_to_signmag_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-2:0] out_mag;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_ovf, busy
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_ovf, busy
  );
endinterface

// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign-magnitude decoder. The magnitude is
// rebuilt LSB-first with the copy-until-first-one-then-invert rule.
module twos_to_signmag #(
  parameter int WIDTH = 12
) (
  input logic              t_clk,
  input logic              rst_n,
  twos_to_signmag_if.slave bus
);
  localparam int MW    = WIDTH - 1;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  logic [MW-1:0]     r_shift;
  logic [MW-1:0]     r_acc;
  logic [MW-1:0]     r_mag;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flag;
  logic              r_sign;
  logic              r_ovf;
  logic              r_valid;
  logic              r_busy;

  logic              w_bit;
  logic              w_res_bit;
  logic              w_flag_next;
  logic              w_ovf;
  logic [MW:0]       w_acc_ext;
  logic [MW-1:0]     w_mag_next;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last;

  // The most-negative word has no positive counterpart; clamp its magnitude.
  function automatic logic [MW-1:0] sat_mag(input logic [MW-1:0] mag,
                                            input logic          ovf);
    return ovf ? {MW{1'b1}} : mag;
  endfunction

  assign w_bit       = r_shift[0];
  assign w_res_bit   = (r_sign && r_flag) ? ~w_bit : w_bit;
  assign w_flag_next = r_flag | (r_sign & w_bit);
  assign w_ovf       = r_sign & ~w_flag_next;
  assign w_acc_ext   = {w_res_bit, r_acc};
  assign w_mag_next  = w_acc_ext[MW:1];
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 2));

  // DONE forwards downstream readiness so a new word can enter with no bubble.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = 1'b1;
      S_DONE:  w_in_ready = bus.out_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_shift <= bus.in_data[MW-1:0];
      r_sign  <= bus.in_data[WIDTH-1];
      r_acc   <= '0;
      r_cnt   <= '0;
      r_flag  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
      r_state <= S_SHIFT;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_shift <= r_shift >> 1;
          r_acc   <= w_mag_next;
          r_flag  <= w_flag_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_mag   <= sat_mag(w_mag_next, w_ovf);
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_sign  = r_sign;
  assign bus.out_mag   = r_mag;
  assign bus.out_ovf   = r_ovf;
  assign bus.busy      = r_busy;
endmodule
